commit_trace_buffer: RTL and testbench

- Sits downstream of the riscv core top and consumes its architectural side-effect outputs: register write-back (reg_write_sig/reg_num/reg_data) and data-memory stores (wr/addr/wr_data).
- Each event becomes a tagged, sequence-numbered trace record, queued in a FIFO and drained by a valid/ready consumer such as a testbench scoreboard or a debug UART.
- Decouples the core, which never stalls, from a slow consumer, and reports any lost records explicitly.

---
 rtl/trace_pkg.sv | 28 ++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/commit_trace_buffer.sv | 120 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record kinds, record payload and drop-count helper.
package trace_pkg;

  localparam int unsigned TR_ADDR_W = 9;
  localparam int unsigned TR_DATA_W = 32;
  localparam int unsigned TR_SEQ_W  = 16;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_REG  = 2'd1,
    TR_MEM  = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [TR_ADDR_W-1:0]   idx;
    logic [TR_DATA_W-1:0]   data;
    logic [TR_SEQ_W-1:0]    seq;
  } trace_rec_t;

  // Saturating add of this cycle's drops onto the running drop count.
  function automatic logic [7:0] drop_sat_add(input logic [7:0] base, input logic [1:0] n);
    logic [8:0] sum;
    sum = {1'b0, base} + 9'(n);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH-entry record FIFO with two ordered write ports and one read port.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push0,
  input  trace_rec_t                   push_rec0,
  input  logic                         push1,
  input  trace_rec_t                   push_rec1,
  input  logic                         pop,
  output trace_rec_t                   head_rec,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_rec_t       mem_q [DEPTH];
  trace_rec_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_nxt;

  // push1 is only ever asserted together with push0, so slot order follows record order.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    if (push0) begin
      mem_d[wr_ptr_q] = push_rec0;
      wr_ptr_d        = wr_ptr_nxt;
    end
    if (push1) begin
      mem_d[wr_ptr_nxt] = push_rec1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(2);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; an empty FIFO presents a zero head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_rec = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Turns core write-back and store side effects into sequence-numbered trace records behind a FIFO.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = TR_DATA_W,
  parameter int unsigned ADDR_W = TR_ADDR_W,
  parameter int unsigned SEQ_W  = TR_SEQ_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              clear_ovf,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [1:0]        trace_kind,
  output logic [ADDR_W-1:0] trace_idx,
  output logic [DATA_W-1:0] trace_data,
  output logic [SEQ_W-1:0]  trace_seq,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic             reg_ev, mem_ev, pop;
  logic [1:0]       n_gen, n_push, n_drop;
  logic [CNT_W-1:0] fifo_count, free;
  trace_rec_t       reg_rec, mem_rec, rec0, head_rec;
  logic             push0, push1;

  // Event detection and record formation; writes to x0 are not architectural.
  always_comb begin
    reg_ev = trace_en & reg_write_sig & (reg_num != 5'd0);
    mem_ev = trace_en & wr;
    n_gen  = {1'b0, reg_ev} + {1'b0, mem_ev};

    reg_rec.kind = TR_REG;
    reg_rec.idx  = TR_ADDR_W'(reg_num);
    reg_rec.data = TR_DATA_W'(reg_data);
    reg_rec.seq  = TR_SEQ_W'(seq_q);

    mem_rec.kind = TR_MEM;
    mem_rec.idx  = TR_ADDR_W'(addr);
    mem_rec.data = TR_DATA_W'(wr_data);
    mem_rec.seq  = TR_SEQ_W'(seq_q + SEQ_W'(reg_ev));

    rec0 = reg_ev ? reg_rec : mem_rec;
  end

  // Capacity: a same-cycle pop frees its slot; excess records beyond free space are dropped in order.
  always_comb begin
    pop    = trace_valid & trace_ready;
    free   = CNT_W'(DEPTH) - fifo_count + CNT_W'(pop);
    n_push = (free >= CNT_W'(n_gen)) ? n_gen : free[1:0];
    n_drop = n_gen - n_push;
    push0  = (n_push != 2'd0);
    push1  = (n_push == 2'd2);
  end

  // Seq advances for dropped records too; a drop outranks a same-cycle clear.
  always_comb begin
    seq_d      = seq_q + SEQ_W'(n_gen);
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
    if (n_drop != 2'd0) begin
      overflow_d = 1'b1;
      drop_d     = drop_sat_add(drop_d, n_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push0     (push0),
    .push_rec0 (rec0),
    .push1     (push1),
    .push_rec1 (mem_rec),
    .pop       (pop),
    .head_rec  (head_rec),
    .count     (fifo_count)
  );

  assign trace_valid = (fifo_count != '0);
  assign trace_kind  = head_rec.kind;
  assign trace_idx   = ADDR_W'(head_rec.idx);
  assign trace_data  = DATA_W'(head_rec.data);
  assign trace_seq   = SEQ_W'(head_rec.seq);
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: directed stimulus queues expected records, a monitor checks them.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_en = 1'b1;
  logic        clear_ovf = 1'b0;
  logic        reg_write_sig = 1'b0;
  logic [4:0]  reg_num = 5'd0;
  logic [31:0] reg_data = 32'd0;
  logic        wr = 1'b0;
  logic [8:0]  addr = 9'd0;
  logic [31:0] wr_data = 32'd0;
  logic        trace_ready = 1'b1;
  logic        trace_valid;
  logic [1:0]  trace_kind;
  logic [8:0]  trace_idx;
  logic [31:0] trace_data;
  logic [15:0] trace_seq;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [58:0] exp_q[$];
  logic [58:0] head_now, head_prev, exp_rec;
  logic        stall_prev = 1'b0;
  logic        rst_prev = 1'b1;

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .trace_en      (trace_en),
    .clear_ovf     (clear_ovf),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .addr          (addr),
    .wr_data       (wr_data),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_kind    (trace_kind),
    .trace_idx     (trace_idx),
    .trace_data    (trace_data),
    .trace_seq     (trace_seq),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] k, input logic [8:0] i, input logic [31:0] d,
                          input logic [15:0] s);
    exp_q.push_back({k, i, d, s});
  endtask

  // Inputs change 1 time unit after the edge and hold for exactly one cycle.
  task automatic step(input logic rw, input logic [4:0] rn, input logic [31:0] rd,
                      input logic w, input logic [8:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reg_write_sig = rw;
    reg_num       = rn;
    reg_data      = rd;
    wr            = w;
    addr          = a;
    wr_data       = wd;
    clear_ovf     = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    reg_write_sig = 1'b0;
    wr = 1'b0;
    clear_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int budget;
    budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: pops expectations on each handshake, checks stall stability and zeroed idle outputs.
  always @(negedge clk) begin
    head_now = {trace_kind, trace_idx, trace_data, trace_seq};
    if (stall_prev && !rst_prev) chk("stall_stable", 64'(head_now), 64'(head_prev));
    if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_record: got %h expected none", head_now);
      end else begin
        exp_rec = exp_q.pop_front();
        chk("record", 64'(head_now), 64'(exp_rec));
      end
    end else if (trace_valid === 1'b0 && !reset) begin
      chk("idle_zero", 64'(head_now), 64'd0);
    end
    stall_prev = (trace_valid === 1'b1) && (trace_ready === 1'b0);
    head_prev  = head_now;
    rst_prev   = reset;
  end

  initial begin
    apply_reset();
    @(negedge clk);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_head", 64'({trace_kind, trace_idx, trace_data, trace_seq}), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // REG then MEM, one per cycle; no same-cycle bypass.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'd0, 32'd0);
    exp_push(2'b01, 9'd5, 32'hDEADBEEF, 16'd0);
    @(negedge clk);
    chk("no_bypass", 64'(trace_valid), 64'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 9'h040, 32'h12345678);
    exp_push(2'b10, 9'h040, 32'h12345678, 16'd1);
    @(negedge clk);
    chk("valid_rise", 64'(trace_valid), 64'd1);
    idle();
    wait_drain("t1");

    // Simultaneous REG and MEM: REG first.
    apply_reset();
    step(1'b1, 5'd3, 32'hA, 1'b1, 9'h1FF, 32'hB);
    exp_push(2'b01, 9'd3, 32'hA, 16'd0);
    exp_push(2'b10, 9'h1FF, 32'hB, 16'd1);
    idle();
    wait_drain("t2");

    // x0 and trace_en filtering.
    apply_reset();
    step(1'b1, 5'd0, 32'h1111, 1'b0, 9'd0, 32'd0);
    step(1'b1, 5'd7, 32'h7777, 1'b0, 9'd0, 32'd0);
    trace_en = 1'b0;
    idle();
    trace_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("filtered_none", 64'(trace_valid), 64'd0);
    end
    step(1'b1, 5'd9, 32'h99, 1'b0, 9'd0, 32'd0);
    exp_push(2'b01, 9'd9, 32'h99, 16'd0);
    idle();
    wait_drain("t3");

    // Overflow, full-with-pop, drop-beats-clear, saturation.
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 9'd0, 32'd0);
      exp_push(2'b01, 9'(i), 32'h1000 + 32'(i), 16'(i - 1));
    end
    step(1'b1, 5'd20, 32'h20, 1'b1, 9'h100, 32'h55);
    idle();
    @(negedge clk);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_drop2", 64'(drop_count), 64'd2);
    step(1'b1, 5'd21, 32'h21, 1'b0, 9'd0, 32'd0);
    trace_ready = 1'b1;
    exp_push(2'b01, 9'd21, 32'h21, 16'd18);
    step(1'b1, 5'd22, 32'h22, 1'b0, 9'd0, 32'd0);
    trace_ready = 1'b0;
    clear_ovf = 1'b1;
    @(negedge clk);
    chk("fwp_no_drop", 64'(drop_count), 64'd2);
    idle();
    @(negedge clk);
    chk("drop_beats_clr_ovf", 64'(overflow), 64'd1);
    chk("drop_beats_clr_cnt", 64'(drop_count), 64'd1);
    repeat (130) step(1'b1, 5'd23, 32'h23, 1'b1, 9'h023, 32'h23);
    idle();
    @(negedge clk);
    chk("drop_saturate", 64'(drop_count), 64'd255);
    clear_ovf = 1'b1;
    idle();
    @(negedge clk);
    chk("clear_ovf", 64'(overflow), 64'd0);
    chk("clear_drop", 64'(drop_count), 64'd0);
    trace_ready = 1'b1;
    wait_drain("t4");

    // Random backpressure over three queued records.
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 1'b0, 9'd0, 32'd0);
      exp_push(2'b01, 9'(10 + i), 32'hC0DE0000 + 32'(i), 16'(i));
    end
    idle();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
      trace_ready = 1'($urandom_range(0, 1));
    end
    trace_ready = 1'b0;
    chk("bp_drain_left", 64'(exp_q.size()), 64'd0);

    // Mid-stream reset discards queued records and restarts seq.
    step(1'b1, 5'd13, 32'hD13, 1'b0, 9'd0, 32'd0);
    step(1'b1, 5'd14, 32'hD14, 1'b0, 9'd0, 32'd0);
    idle();
    @(negedge clk);
    chk("pre_reset_valid", 64'(trace_valid), 64'd1);
    apply_reset();
    @(negedge clk);
    chk("reset_flush", 64'(trace_valid), 64'd0);
    exp_q.delete();
    trace_ready = 1'b1;
    step(1'b1, 5'd15, 32'hF, 1'b0, 9'd0, 32'd0);
    exp_push(2'b01, 9'd15, 32'hF, 16'd0);
    idle();
    wait_drain("t5");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
